// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: syncs, active flag, coordinates and line/frame strobes; one enabled-cycle latency.
// No backpressure; i_pixEn throttles the pixel rate. Define VGA_PATTERN_EN to add the registered test-pattern RGB outputs.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   COUNT_W    = 10
) (
  input  logic               i_clk,
  input  logic               i_resetN,
  input  logic               i_pixEn,
`ifdef VGA_PATTERN_EN
  input  logic [1:0]         i_patternSel,
  output logic [2:0]         o_red,
  output logic [2:0]         o_green,
  output logic [2:0]         o_blue,
`endif
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_activeArea,
  output logic [COUNT_W-1:0] o_px,
  output logic [COUNT_W-1:0] o_py,
  output logic               o_lineStart,
  output logic               o_frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_ACT    = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT    = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] H_SYNC_S = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] H_SYNC_E = COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNT_W-1:0] V_SYNC_S = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] V_SYNC_E = COUNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COUNT_W-1:0] h_cnt;
  logic [COUNT_W-1:0] v_cnt;
  logic               h_wrap;
  logic               h_in_sync;
  logic               v_in_sync;
  logic               active_now;

  assign h_wrap     = (h_cnt == H_LAST);
  assign h_in_sync  = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
  assign v_in_sync  = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
  assign active_now = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_pixEn) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) begin
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
    end
  end

  // Outputs describe the pre-edge counters; strobes self-clear on any edge.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      o_hs         <= ~H_SYNC_POL;
      o_vs         <= ~V_SYNC_POL;
      o_activeArea <= 1'b0;
      o_px         <= '0;
      o_py         <= '0;
      o_lineStart  <= 1'b0;
      o_frameStart <= 1'b0;
    end else begin
      o_lineStart  <= 1'b0;
      o_frameStart <= 1'b0;
      if (i_pixEn) begin
        o_hs         <= h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
        o_vs         <= v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
        o_activeArea <= active_now;
        o_px         <= h_cnt;
        o_py         <= v_cnt;
        o_lineStart  <= (h_cnt == '0);
        o_frameStart <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

`ifdef VGA_PATTERN_EN
  logic [2:0] bar;
  logic [8:0] pat_rgb;

  // Bar index (px*8)/H_ACTIVE, resolved as compares against constant thresholds.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h_cnt) * 8 >= k * H_ACTIVE) begin
        bar = 3'(k);
      end
    end
  end

  always_comb begin
    pat_rgb = 9'd0;
    case (i_patternSel)
      2'd1:    pat_rgb = {{3{bar[2]}}, {3{bar[1]}}, {3{bar[0]}}};
      2'd2:    pat_rgb = (h_cnt[5] ^ v_cnt[5]) ? 9'h1FF : 9'h000;
      2'd3:    pat_rgb = 9'h1FF;
      default: pat_rgb = 9'd0;
    endcase
    if (!active_now) begin
      pat_rgb = 9'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      o_red   <= 3'd0;
      o_green <= 3'd0;
      o_blue  <= 3'd0;
    end else if (i_pixEn) begin
      {o_red, o_green, o_blue} <= pat_rgb;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small-geometry vector table, multi-cycle sequences for wrap, enable duty, reset and polarity, default-geometry line.
module tb_vga_timing_gen;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  always #5 i_clk = ~i_clk;

  logic       s_hs, s_vs, s_act, s_ls, s_fs;
  logic [9:0] s_px, s_py;
  logic       p_hs, p_vs, p_act, p_ls, p_fs;
  logic [9:0] p_px, p_py;
  logic       d_hs, d_vs, d_act, d_ls, d_fs;
  logic [9:0] d_px, d_py;

`ifdef VGA_PATTERN_EN
  logic [1:0] sel = 2'd1;
  logic [2:0] s_r, s_g, s_b, p_r, p_g, p_b, d_r, d_g, d_b;
`endif

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_small (
    .i_clk(i_clk), .i_resetN(rst_n), .i_pixEn(pix_en),
`ifdef VGA_PATTERN_EN
    .i_patternSel(sel), .o_red(s_r), .o_green(s_g), .o_blue(s_b),
`endif
    .o_hs(s_hs), .o_vs(s_vs), .o_activeArea(s_act), .o_px(s_px), .o_py(s_py),
    .o_lineStart(s_ls), .o_frameStart(s_fs));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) u_pol (
    .i_clk(i_clk), .i_resetN(rst_n), .i_pixEn(1'b1),
`ifdef VGA_PATTERN_EN
    .i_patternSel(sel), .o_red(p_r), .o_green(p_g), .o_blue(p_b),
`endif
    .o_hs(p_hs), .o_vs(p_vs), .o_activeArea(p_act), .o_px(p_px), .o_py(p_py),
    .o_lineStart(p_ls), .o_frameStart(p_fs));

  vga_timing_gen u_def (
    .i_clk(i_clk), .i_resetN(rst_n), .i_pixEn(1'b1),
`ifdef VGA_PATTERN_EN
    .i_patternSel(sel), .o_red(d_r), .o_green(d_g), .o_blue(d_b),
`endif
    .o_hs(d_hs), .o_vs(d_vs), .o_activeArea(d_act), .o_px(d_px), .o_py(d_py),
    .o_lineStart(d_ls), .o_frameStart(d_fs));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    pix_en = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic en;
    logic hs;
    logic vs;
    logic act;
    int   px;
    int   py;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int hs_lo, vs_lo, act_n, ls_n, fs_n, fs_first, fs_second, ph_hi, pv_hi, pact_n;
    int exp_px, exp_py, dbl_ls, first_hs;
    logic prev_ls;

    // Small geometry: H 0..7 active, 10..11 sync, total 14; V 0..3 active, 5 sync, total 7.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0,  0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 0,  0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1,  0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2,  0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3,  0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4,  0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5,  0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 6,  0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7,  0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8,  0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8,  0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 9,  0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 11, 0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 12, 0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 13, 0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 0,  1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 0,  1, 1'b0, 1'b0};

    do_reset();
    #1;
    check("rst_hs", s_hs, 1);
    check("rst_vs", s_vs, 1);
    check("rst_act", s_act, 0);
    check("rst_px", s_px, 0);
    check("rst_py", s_py, 0);
    check("rst_ls", s_ls, 0);
    check("rst_fs", s_fs, 0);
    check("rst_pol_hs", p_hs, 0);
    check("rst_pol_vs", p_vs, 0);

    for (int i = 0; i < 18; i++) begin
      pix_en = tbl[i].en;
      @(posedge i_clk);
      #1;
      check($sformatf("v%0d_hs", i), s_hs, tbl[i].hs);
      check($sformatf("v%0d_vs", i), s_vs, tbl[i].vs);
      check($sformatf("v%0d_act", i), s_act, tbl[i].act);
      check($sformatf("v%0d_px", i), s_px, tbl[i].px);
      check($sformatf("v%0d_py", i), s_py, tbl[i].py);
      check($sformatf("v%0d_ls", i), s_ls, tbl[i].ls);
      check($sformatf("v%0d_fs", i), s_fs, tbl[i].fs);
    end

    // Two full small frames at full rate, plus the inverted-polarity twin.
    do_reset();
    pix_en = 1'b1;
    hs_lo = 0; vs_lo = 0; act_n = 0; ls_n = 0; fs_n = 0; fs_first = -1; fs_second = -1;
    ph_hi = 0; pv_hi = 0; pact_n = 0; exp_px = 0; exp_py = 0;
    for (int c = 0; c < 196; c++) begin
      @(posedge i_clk);
      #1;
      check($sformatf("wrap_px%0d", c), s_px, exp_px);
      check($sformatf("wrap_py%0d", c), s_py, exp_py);
      if (exp_px == 13) begin
        exp_px = 0;
        exp_py = (exp_py == 6) ? 0 : exp_py + 1;
      end else begin
        exp_px++;
      end
      if (!s_hs) hs_lo++;
      if (!s_vs) vs_lo++;
      if (s_act) act_n++;
      if (s_ls) ls_n++;
      if (s_fs) begin
        fs_n++;
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
      if (p_hs) ph_hi++;
      if (p_vs) pv_hi++;
      if (p_act) pact_n++;
    end
    check("a_hs_low", hs_lo, 28);
    check("a_vs_low", vs_lo, 28);
    check("a_active", act_n, 64);
    check("a_linestarts", ls_n, 14);
    check("a_framestarts", fs_n, 2);
    check("a_frame_period", fs_second - fs_first, 98);
    check("pol_hs_high", ph_hi, 28);
    check("pol_vs_high", pv_hi, 28);
    check("pol_active", pact_n, 64);

    // Enable at half duty: widths double in i_clk cycles, strobes stay single-cycle.
    do_reset();
    hs_lo = 0; vs_lo = 0; ls_n = 0; fs_n = 0; dbl_ls = 0; prev_ls = 1'b0;
    for (int c = 0; c < 392; c++) begin
      pix_en = ((c % 2) == 0);
      @(posedge i_clk);
      #1;
      if (!s_hs) hs_lo++;
      if (!s_vs) vs_lo++;
      if (s_ls) ls_n++;
      if (s_fs) fs_n++;
      if (s_ls && prev_ls) dbl_ls++;
      prev_ls = s_ls;
    end
    check("b_hs_low", hs_lo, 56);
    check("b_vs_low", vs_lo, 56);
    check("b_linestart_cycles", ls_n, 14);
    check("b_framestart_cycles", fs_n, 2);
    check("b_wide_strobe", dbl_ls, 0);

    // Reset asserted while the output describes (4,5), inside V sync.
    do_reset();
    pix_en = 1'b1;
    repeat (75) @(posedge i_clk);
    #1;
    check("c_pre_vs", s_vs, 0);
    check("c_pre_px", s_px, 4);
    check("c_pre_py", s_py, 5);
    #1 rst_n = 1'b0;
    #1;
    check("c_rst_vs", s_vs, 1);
    check("c_rst_px", s_px, 0);
    check("c_rst_py", s_py, 0);
    check("c_rst_act", s_act, 0);
    @(negedge i_clk);
    rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("c_first_px", s_px, 0);
    check("c_first_py", s_py, 0);
    check("c_first_fs", s_fs, 1);
    check("c_first_ls", s_ls, 1);
    check("c_first_act", s_act, 1);

    // Default 800-pixel geometry: first two lines.
    do_reset();
    hs_lo = 0; act_n = 0; ls_n = 0; fs_n = 0; first_hs = -1;
    for (int c = 0; c < 1600; c++) begin
      @(posedge i_clk);
      #1;
      if (!d_hs) begin
        hs_lo++;
        if (first_hs < 0) first_hs = c;
      end
      if (d_act) act_n++;
      if (d_ls) ls_n++;
      if (d_fs) fs_n++;
`ifdef VGA_PATTERN_EN
      if (d_px < 80)
        check($sformatf("pat_black_px%0d", d_px), {d_r, d_g, d_b}, 9'h000);
      else if (d_px >= 80 && d_px < 160)
        check($sformatf("pat_blue_px%0d", d_px), {d_r, d_g, d_b}, 9'h007);
      else if (d_px >= 560 && d_px < 640)
        check($sformatf("pat_white_px%0d", d_px), {d_r, d_g, d_b}, 9'h1FF);
      else if (d_px == 640)
        check("pat_blank_px640", {d_r, d_g, d_b}, 9'h000);
`endif
    end
    check("d_hs_low", hs_lo, 192);
    check("d_hs_first", first_hs, 656);
    check("d_active", act_n, 1280);
    check("d_linestarts", ls_n, 2);
    check("d_framestarts", fs_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
